spi_reg_sequencer: RTL and testbench

//  Register-access front end that sits directly upstream of the SPI transaction engine. Accepts one read/write

---
 rtl/spi_reg_sequencer_if.sv | 45 ++++
 rtl/spi_reg_sequencer.sv | 151 +++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_sequencer_if.sv
// Bundles the command, response and SPI-engine handshake signals of spi_reg_sequencer.
// slave: the sequencer's view; master: the environment (command issuer plus SPI engine).
interface spi_reg_sequencer_if #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 8,
    parameter int SPI_LEN_WIDTH = 5,
    parameter int SPI_MAX_LEN   = 16
);
    logic                     cmd_valid_i;
    logic                     cmd_ready_o;
    logic                     cmd_write_i;
    logic [ADDR_WIDTH-1:0]    cmd_addr_i;
    logic [DATA_WIDTH-1:0]    cmd_wdata_i;

    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic [DATA_WIDTH-1:0]    rsp_rdata_o;
    logic                     rsp_write_o;

    logic                     spi_wrvalid_o;
    logic                     spi_wrready_i;
    logic [SPI_LEN_WIDTH-1:0] spi_wrlen_o;
    logic [SPI_MAX_LEN-1:0]   spi_wrdata_o;
    logic                     spi_rdvalid_i;
    logic                     spi_rdready_o;
    logic [SPI_MAX_LEN-1:0]   spi_rddata_i;

    modport slave (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        input  rsp_ready_i,
        input  spi_wrready_i, spi_rdvalid_i, spi_rddata_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_write_o,
        output spi_wrvalid_o, spi_wrlen_o, spi_wrdata_o, spi_rdready_o
    );

    modport master (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i,
        output rsp_ready_i,
        output spi_wrready_i, spi_rdvalid_i, spi_rddata_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_write_o,
        input  spi_wrvalid_o, spi_wrlen_o, spi_wrdata_o, spi_rdready_o
    );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Register-access front end for the SPI transaction engine: one command in flight, packed into one frame.
// Optional SPI_REG_SEQ_STATS_EN adds write/read response counters with a synchronous clear.
module spi_reg_sequencer #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 8,
    parameter int SPI_LEN_WIDTH = 5,
    parameter int SPI_MAX_LEN   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    spi_reg_sequencer_if.slave  bus
`ifdef SPI_REG_SEQ_STATS_EN
    ,
    input  logic                stat_clear_i,
    output logic [15:0]         stat_wr_count_o,
    output logic [15:0]         stat_rd_count_o
`endif
);

    localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_RESPOND
    } state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    spi_wrvalid_q, spi_wrvalid_d;
    logic                    spi_rdready_q, spi_rdready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [SPI_MAX_LEN-1:0]  frame_q, frame_d;

    logic                    cmd_hs, wr_hs, rd_hs, rsp_hs;
    logic [DATA_WIDTH-1:0]   wdata_field;
    logic [SPI_MAX_LEN-1:0]  frame_new;

    // Handshakes qualify with registered enables only, so no input reaches an output combinationally.
    assign cmd_hs = bus.cmd_valid_i   && cmd_ready_q;
    assign wr_hs  = bus.spi_wrready_i && spi_wrvalid_q;
    assign rd_hs  = bus.spi_rdvalid_i && spi_rdready_q;
    assign rsp_hs = bus.rsp_ready_i   && rsp_valid_q;

    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise untaken branches infer latches.
        state_d     = state_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        frame_d     = frame_q;

        wdata_field = bus.cmd_write_i ? bus.cmd_wdata_i : '0;
        frame_new   = '0;
        frame_new[FRAME_W-1:0] = {~bus.cmd_write_i, bus.cmd_addr_i, wdata_field};

        unique case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    frame_d     = frame_new;
                    rsp_write_d = bus.cmd_write_i;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_hs) state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (rd_hs) begin
                    rsp_rdata_d = rsp_write_q ? '0 : bus.spi_rddata_i[DATA_WIDTH-1:0];
                    state_d     = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (rsp_hs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Output enables follow the next state so each is high exactly in its own state.
        cmd_ready_d   = (state_d == S_IDLE);
        spi_wrvalid_d = (state_d == S_ISSUE);
        spi_rdready_d = (state_d == S_WAIT_RD);
        rsp_valid_d   = (state_d == S_RESPOND);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            cmd_ready_q   <= 1'b0;
            spi_wrvalid_q <= 1'b0;
            spi_rdready_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            frame_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of order.
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            spi_wrvalid_q <= spi_wrvalid_d;
            spi_rdready_q <= spi_rdready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            frame_q       <= frame_d;
        end
    end

    assign bus.cmd_ready_o   = cmd_ready_q;
    assign bus.spi_wrvalid_o = spi_wrvalid_q;
    assign bus.spi_rdready_o = spi_rdready_q;
    assign bus.spi_wrdata_o  = frame_q;
    assign bus.spi_wrlen_o   = SPI_LEN_WIDTH'(FRAME_W);
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_write_o   = rsp_write_q;
    assign bus.rsp_rdata_o   = rsp_rdata_q;

`ifdef SPI_REG_SEQ_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;

    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (stat_clear_i) begin
            stat_wr_d = '0;
            stat_rd_d = '0;
        end else if (rsp_hs) begin
            if (rsp_write_q) stat_wr_d = stat_wr_q + 16'd1;
            else             stat_rd_d = stat_rd_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr_count_o = stat_wr_q;
    assign stat_rd_count_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed self-checking bench for spi_reg_sequencer; the SPI engine is modelled by hand-driven handshakes.
// Define SPI_REG_SEQ_STATS_EN on both RTL and bench to exercise the statistics counters.
module tb_spi_reg_sequencer;

    localparam int ADDR_WIDTH    = 7;
    localparam int DATA_WIDTH    = 8;
    localparam int SPI_LEN_WIDTH = 5;
    localparam int SPI_MAX_LEN   = 16;
    localparam int WAIT_LIMIT    = 20;

    logic clk_i = 1'b0;
    logic rst_ni;

    always #5 clk_i = ~clk_i;

    spi_reg_sequencer_if #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .SPI_LEN_WIDTH(SPI_LEN_WIDTH), .SPI_MAX_LEN(SPI_MAX_LEN)
    ) bus ();

`ifdef SPI_REG_SEQ_STATS_EN
    logic        stat_clear_i;
    logic [15:0] stat_wr_count_o;
    logic [15:0] stat_rd_count_o;
`endif

    spi_reg_sequencer #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .SPI_LEN_WIDTH(SPI_LEN_WIDTH), .SPI_MAX_LEN(SPI_MAX_LEN)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
`ifdef SPI_REG_SEQ_STATS_EN
        ,
        .stat_clear_i   (stat_clear_i),
        .stat_wr_count_o(stat_wr_count_o),
        .stat_rd_count_o(stat_rd_count_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic timeout(input string what);
        n_checks++;
        $display("FAIL %s: no handshake within %0d cycles, required one", what, WAIT_LIMIT);
    endtask

    task automatic send_cmd(input logic w, input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        while (bus.cmd_ready_o !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (bus.cmd_ready_o !== 1'b1) begin
            timeout("send_cmd");
            return;
        end
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = w;
        bus.cmd_addr_i  = a;
        bus.cmd_wdata_i = d;
        tick();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic engine_wr();
        int n = 0;
        while (bus.spi_wrvalid_o !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (bus.spi_wrvalid_o !== 1'b1) begin
            timeout("engine_wr");
            return;
        end
        bus.spi_wrready_i = 1'b1;
        tick();
        bus.spi_wrready_i = 1'b0;
    endtask

    task automatic engine_rd(input logic [15:0] rd);
        int n = 0;
        while (bus.spi_rdready_o !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (bus.spi_rdready_o !== 1'b1) begin
            timeout("engine_rd");
            return;
        end
        bus.spi_rdvalid_i = 1'b1;
        bus.spi_rddata_i  = rd;
        tick();
        bus.spi_rdvalid_i = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (bus.rsp_valid_o !== 1'b1 && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (bus.rsp_valid_o !== 1'b1) timeout("wait_rsp");
    endtask

    task automatic take_rsp(output logic [7:0] rdata, output logic w);
        wait_rsp();
        rdata = bus.rsp_rdata_o;
        w     = bus.rsp_write_o;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.cmd_ready_o !== 1'b0) $display("FAIL reset_cmd_ready: got %b, expected 0", bus.cmd_ready_o); else n_pass++;
        n_checks++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL reset_rsp_valid: got %b, expected 0", bus.rsp_valid_o); else n_pass++;
        n_checks++; if (bus.spi_wrvalid_o !== 1'b0) $display("FAIL reset_wrvalid: got %b, expected 0", bus.spi_wrvalid_o); else n_pass++;
        n_checks++; if (bus.spi_rdready_o !== 1'b0) $display("FAIL reset_rdready: got %b, expected 0", bus.spi_rdready_o); else n_pass++;
        n_checks++; if (bus.spi_wrdata_o !== 16'h0000) $display("FAIL reset_wrdata: got %h, expected 0000", bus.spi_wrdata_o); else n_pass++;
        n_checks++; if (bus.rsp_rdata_o !== 8'h00) $display("FAIL reset_rsp_rdata: got %h, expected 00", bus.rsp_rdata_o); else n_pass++;
        n_checks++; if (bus.rsp_write_o !== 1'b0) $display("FAIL reset_rsp_write: got %b, expected 0", bus.rsp_write_o); else n_pass++;
        rst_ni = 1'b1;
        tick();
        n_checks++; if (bus.cmd_ready_o !== 1'b1) $display("FAIL release_cmd_ready: got %b, expected 1", bus.cmd_ready_o); else n_pass++;
        n_checks++; if (bus.spi_wrlen_o !== 5'd16) $display("FAIL wrlen: got %0d, expected 16", bus.spi_wrlen_o); else n_pass++;
    endtask

    task automatic test_write();
        logic [7:0] rdata;
        logic       w;
        send_cmd(1'b1, 7'h12, 8'hA5);
        n_checks++; if (bus.spi_wrvalid_o !== 1'b1) $display("FAIL write_wrvalid: got %b, expected 1", bus.spi_wrvalid_o); else n_pass++;
        n_checks++; if (bus.spi_wrdata_o !== 16'h12A5) $display("FAIL write_frame: got %h, expected 12a5", bus.spi_wrdata_o); else n_pass++;
        n_checks++; if (bus.cmd_ready_o !== 1'b0) $display("FAIL write_cmd_ready_busy: got %b, expected 0", bus.cmd_ready_o); else n_pass++;
        engine_wr();
        n_checks++; if (bus.spi_rdready_o !== 1'b1) $display("FAIL write_rdready: got %b, expected 1", bus.spi_rdready_o); else n_pass++;
        engine_rd(16'hFFFF);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b1) $display("FAIL write_rsp_write: got %b, expected 1", w); else n_pass++;
        n_checks++; if (rdata !== 8'h00) $display("FAIL write_rsp_rdata: got %h, expected 00", rdata); else n_pass++;
        n_checks++; if (bus.cmd_ready_o !== 1'b1) $display("FAIL write_ready_after_rsp: got %b, expected 1", bus.cmd_ready_o); else n_pass++;
    endtask

    task automatic test_read();
        logic [7:0] rdata;
        logic       w;
        send_cmd(1'b0, 7'h05, 8'h77);
        n_checks++; if (bus.spi_wrdata_o !== 16'h8500) $display("FAIL read_frame: got %h, expected 8500", bus.spi_wrdata_o); else n_pass++;
        engine_wr();
        engine_rd(16'h00C3);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b0) $display("FAIL read_rsp_write: got %b, expected 0", w); else n_pass++;
        n_checks++; if (rdata !== 8'hC3) $display("FAIL read_rsp_rdata: got %h, expected c3", rdata); else n_pass++;
    endtask

    task automatic test_wrready_stall();
        logic [7:0] rdata;
        logic       w;
        logic       stable = 1'b1;
        send_cmd(1'b1, 7'h7F, 8'h3C);
        // A competing command and a stray read beat are both offered while the frame is stalled.
        bus.cmd_valid_i   = 1'b1;
        bus.cmd_write_i   = 1'b0;
        bus.cmd_addr_i    = 7'h11;
        bus.spi_rdvalid_i = 1'b1;
        bus.spi_rddata_i  = 16'h00EE;
        for (int i = 0; i < 10; i++) begin
            if (bus.spi_wrvalid_o !== 1'b1 || bus.spi_wrdata_o !== 16'h7F3C ||
                bus.cmd_ready_o !== 1'b0 || bus.spi_rdready_o !== 1'b0) stable = 1'b0;
            tick();
        end
        bus.cmd_valid_i   = 1'b0;
        bus.spi_rdvalid_i = 1'b0;
        n_checks++; if (stable !== 1'b1) $display("FAIL stall_stable: got %b, expected 1", stable); else n_pass++;
        n_checks++; if (bus.spi_wrdata_o !== 16'h7F3C) $display("FAIL stall_frame: got %h, expected 7f3c", bus.spi_wrdata_o); else n_pass++;
        engine_wr();
        engine_rd(16'h0042);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b1 || rdata !== 8'h00) $display("FAIL stall_rsp: got write=%b rdata=%h, expected write=1 rdata=00", w, rdata); else n_pass++;
    endtask

    task automatic test_rsp_backpressure();
        logic [7:0] rdata;
        logic       w;
        logic       stable = 1'b1;
        send_cmd(1'b0, 7'h2A, 8'h00);
        engine_wr();
        engine_rd(16'hBE5A);
        wait_rsp();
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 7'h01;
        bus.cmd_wdata_i = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 8'h5A ||
                bus.rsp_write_o !== 1'b0 || bus.cmd_ready_o !== 1'b0) stable = 1'b0;
            tick();
        end
        n_checks++; if (stable !== 1'b1) $display("FAIL rsp_hold_stable: got %b, expected 1", stable); else n_pass++;
        bus.rsp_ready_i = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        n_checks++; if (bus.rsp_valid_o !== 1'b0) $display("FAIL rsp_consumed: got %b, expected 0", bus.rsp_valid_o); else n_pass++;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++; if (bus.spi_wrdata_o !== 16'h01FF) $display("FAIL second_cmd_frame: got %h, expected 01ff", bus.spi_wrdata_o); else n_pass++;
        engine_wr();
        engine_rd(16'h1234);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b1 || rdata !== 8'h00) $display("FAIL second_cmd_rsp: got write=%b rdata=%h, expected write=1 rdata=00", w, rdata); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] rdata;
        logic       w;
        send_cmd(1'b0, 7'h33, 8'h00);
        engine_wr();
        n_checks++; if (bus.spi_rdready_o !== 1'b1) $display("FAIL midreset_in_wait_rd: got %b, expected 1", bus.spi_rdready_o); else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.spi_rdready_o !== 1'b0 || bus.cmd_ready_o !== 1'b0 || bus.spi_wrvalid_o !== 1'b0 || bus.rsp_valid_o !== 1'b0)
            $display("FAIL midreset_ctrl: got rdready=%b ready=%b wrvalid=%b rsp_valid=%b, expected all 0",
                     bus.spi_rdready_o, bus.cmd_ready_o, bus.spi_wrvalid_o, bus.rsp_valid_o);
        else n_pass++;
        n_checks++; if (bus.spi_wrdata_o !== 16'h0000 || bus.rsp_rdata_o !== 8'h00 || bus.rsp_write_o !== 1'b0)
            $display("FAIL midreset_data: got wrdata=%h rdata=%h write=%b, expected 0000 00 0",
                     bus.spi_wrdata_o, bus.rsp_rdata_o, bus.rsp_write_o);
        else n_pass++;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        n_checks++; if (bus.cmd_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) $display("FAIL midreset_release: got ready=%b rsp_valid=%b, expected 1 0", bus.cmd_ready_o, bus.rsp_valid_o); else n_pass++;
        send_cmd(1'b0, 7'h44, 8'h00);
        n_checks++; if (bus.spi_wrdata_o !== 16'hC400) $display("FAIL midreset_new_frame: got %h, expected c400", bus.spi_wrdata_o); else n_pass++;
        engine_wr();
        engine_rd(16'h0099);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b0 || rdata !== 8'h99) $display("FAIL midreset_new_rsp: got write=%b rdata=%h, expected write=0 rdata=99", w, rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rdata;
        logic       w;
        // Engine answers immediately, so only the minimum ISSUE and WAIT_RD cycles remain.
        bus.spi_wrready_i = 1'b1;
        bus.spi_rdvalid_i = 1'b1;
        bus.spi_rddata_i  = 16'h0011;
        send_cmd(1'b0, 7'h10, 8'h00);
        n_checks++; if (bus.spi_wrdata_o !== 16'h9000 || bus.rsp_valid_o !== 1'b0) $display("FAIL b2b_issue: got wrdata=%h rsp_valid=%b, expected 9000 0", bus.spi_wrdata_o, bus.rsp_valid_o); else n_pass++;
        tick();
        n_checks++; if (bus.spi_rdready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) $display("FAIL b2b_wait_rd: got rdready=%b rsp_valid=%b, expected 1 0", bus.spi_rdready_o, bus.rsp_valid_o); else n_pass++;
        tick();
        bus.spi_wrready_i = 1'b0;
        bus.spi_rdvalid_i = 1'b0;
        n_checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_rdata_o !== 8'h11) $display("FAIL b2b_latency: got rsp_valid=%b rdata=%h, expected 1 11", bus.rsp_valid_o, bus.rsp_rdata_o); else n_pass++;
        bus.rsp_ready_i = 1'b1;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_write_i = 1'b1;
        bus.cmd_addr_i  = 7'h55;
        bus.cmd_wdata_i = 8'h0F;
        tick();
        bus.rsp_ready_i = 1'b0;
        n_checks++; if (bus.cmd_ready_o !== 1'b1 || bus.spi_wrvalid_o !== 1'b0) $display("FAIL b2b_bubble: got ready=%b wrvalid=%b, expected 1 0", bus.cmd_ready_o, bus.spi_wrvalid_o); else n_pass++;
        tick();
        bus.cmd_valid_i = 1'b0;
        n_checks++; if (bus.spi_wrvalid_o !== 1'b1 || bus.spi_wrdata_o !== 16'h550F) $display("FAIL b2b_second: got wrvalid=%b wrdata=%h, expected 1 550f", bus.spi_wrvalid_o, bus.spi_wrdata_o); else n_pass++;
        engine_wr();
        engine_rd(16'h0000);
        take_rsp(rdata, w);
        n_checks++; if (w !== 1'b1) $display("FAIL b2b_second_rsp: got write=%b, expected 1", w); else n_pass++;
    endtask

`ifdef SPI_REG_SEQ_STATS_EN
    task automatic test_stats();
        logic [7:0] rdata;
        logic       w;
        stat_clear_i = 1'b1;
        tick();
        stat_clear_i = 1'b0;
        n_checks++; if (stat_wr_count_o !== 16'd0 || stat_rd_count_o !== 16'd0) $display("FAIL stats_clear: got wr=%0d rd=%0d, expected 0 0", stat_wr_count_o, stat_rd_count_o); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            send_cmd(i < 3, 7'(i), 8'(i));
            engine_wr();
            engine_rd(16'h0001);
            take_rsp(rdata, w);
        end
        n_checks++; if (stat_wr_count_o !== 16'd3 || stat_rd_count_o !== 16'd2) $display("FAIL stats_count: got wr=%0d rd=%0d, expected 3 2", stat_wr_count_o, stat_rd_count_o); else n_pass++;
        send_cmd(1'b1, 7'h0A, 8'h0B);
        engine_wr();
        engine_rd(16'h0000);
        wait_rsp();
        bus.rsp_ready_i = 1'b1;
        stat_clear_i    = 1'b1;
        tick();
        bus.rsp_ready_i = 1'b0;
        stat_clear_i    = 1'b0;
        n_checks++; if (stat_wr_count_o !== 16'd0 || stat_rd_count_o !== 16'd0) $display("FAIL stats_clear_wins: got wr=%0d rd=%0d, expected 0 0", stat_wr_count_o, stat_rd_count_o); else n_pass++;
    endtask
`endif

    initial begin
        rst_ni            = 1'b0;
        bus.cmd_valid_i   = 1'b0;
        bus.cmd_write_i   = 1'b0;
        bus.cmd_addr_i    = '0;
        bus.cmd_wdata_i   = '0;
        bus.rsp_ready_i   = 1'b0;
        bus.spi_wrready_i = 1'b0;
        bus.spi_rdvalid_i = 1'b0;
        bus.spi_rddata_i  = '0;
`ifdef SPI_REG_SEQ_STATS_EN
        stat_clear_i      = 1'b0;
`endif
        test_reset();
        test_write();
        test_read();
        test_wrready_stall();
        test_rsp_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
`ifdef SPI_REG_SEQ_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
